// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between the BCD source, the scan controller and the shared segment decoder/pins.
interface seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_blank_en;
  logic [3:0]              dec_digit;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    dp_n;
  logic                    frame_tick;

  modport master (
    output digits_in, dp_in, lz_blank_en,
    input  dec_digit, an_n, dp_n, frame_tick
  );

  modport slave (
    input  digits_in, dp_in, lz_blank_en,
    output dec_digit, an_n, dp_n, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a tear-free frame buffer.
// Define SEG_SCAN_DEADTIME_EN to keep the first BLANK_CYCLES of every slot dark.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave scan_io
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

`ifdef SEG_SCAN_DEADTIME_EN
  localparam bit DeadEn = 1'b1;
`else
  localparam bit DeadEn = 1'b0;
`endif

  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] DeadLen = CntW'(BLANK_CYCLES);

  typedef enum logic [0:0] {StDead, StDrive} state_e;

  localparam state_e StInit = (DeadEn && (BLANK_CYCLES > 0)) ? StDead : StDrive;

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  state_e                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   dpb_q, dpb_d;
  logic                    first_q, first_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [3:0]              dec_q, dec_d;
  logic                    dp_n_q, dp_n_d;
  logic                    tick_q, tick_d;

  logic                    slot_end;
  logic                    frame_end;
  logic                    frame_start;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= StInit;
      dig_q   <= scan_io.digits_in;
      dpb_q   <= scan_io.dp_in;
      first_q <= 1'b1;
      an_n_q  <= '1;
      dec_q   <= 4'hF;
      dp_n_q  <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      dig_q   <= dig_d;
      dpb_q   <= dpb_d;
      first_q <= first_d;
      an_n_q  <= an_n_d;
      dec_q   <= dec_d;
      dp_n_q  <= dp_n_d;
      tick_q  <= tick_d;
    end
  end

  // Slot/digit sequencing; the state always describes the slot position held in cnt_q.
  always_comb begin
    slot_end    = (cnt_q == CntLast);
    frame_end   = slot_end && (idx_q == IdxLast);
    frame_start = (cnt_q == '0) && (idx_q == '0);
    cnt_d       = cnt_q + CntW'(1);
    idx_d       = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
    state_d = (DeadEn && (cnt_d < DeadLen)) ? StDead : StDrive;
    dig_d   = frame_end ? scan_io.digits_in : dig_q;
    dpb_d   = frame_end ? scan_io.dp_in : dpb_q;
    first_d = first_q && !frame_start;
  end

  // A digit goes dark when it and every more significant buffered digit is zero.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run && (dig_q[4*i +: 4] == 4'd0);
      blank[i] = zero_run && (i != 0) && scan_io.lz_blank_en;
    end
  end

  assign cur_digit = dig_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    an_n_d = '1;
    dec_d  = 4'hF;
    dp_n_d = 1'b1;
    tick_d = frame_start && !first_q;
    unique case (state_q)
      StDead: ;
      StDrive: begin
        if (!blank[idx_q]) begin
          an_n_d = ~(NUM_DIGITS'(1) << idx_q);
          dec_d  = cur_digit;
          dp_n_d = ~dpb_q[idx_q];
        end
      end
      default: ;
    endcase
  end

  assign scan_io.an_n       = an_n_q;
  assign scan_io.dec_digit  = dec_q;
  assign scan_io.dp_n       = dp_n_q;
  assign scan_io.frame_tick = tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the digital clock's common-anode seven-segment display. It shares a single BCD-to-segment decoder across `NUM_DIGITS` digit positions. Each refresh slot, it drives one active-low anode and presents that digit's code to the decoder. It also applies leading-zero blanking and decimal points, and signals frame boundaries. It sits between the timekeeping counters, which supply packed BCD, and the shared decoder/pins.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digits; legal range 2–8.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; must be ≥ 4.
- `BLANK_CYCLES`, default 500: dead-time cycles at the start of each slot; must be < `REFRESH_DIV`. Used only with `SEG_SCAN_DEADTIME_EN`.
- `clk`, input, 1: system clock. One clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `digits_in`, input, 4*`NUM_DIGITS`: packed BCD. Bits [4i+3:4i] are digit i; digit 0 is least significant (rightmost).
- `dp_in`, input, `NUM_DIGITS`: decimal point request per digit, active-high.
- `lz_blank_en`, input, 1: leading-zero blanking enable.
- `dec_digit`, output, 4: code sent to the shared decoder. 4'hF makes the decoder output all segments off.
- `an_n`, output, `NUM_DIGITS`: anode enables, active-low, at most one low at a time.
- `dp_n`, output, 1: decimal point segment, active-low.
- `frame_tick`, output, 1: one-cycle pulse marking the start of each new frame.

## Operation
- Slot counter `cnt` runs 0..`REFRESH_DIV`-1 every cycle and wraps to 0.
- On each wrap, digit index `idx` advances; from `NUM_DIGITS`-1 it returns to 0.
- Display buffer (`digits_in`, `dp_in`) is captured:
  - every cycle while `rst` is high;
  - on the cycle where `cnt`=`REFRESH_DIV`-1 and `idx`=`NUM_DIGITS`-1.
  - Input changes mid-frame never tear a frame.
- Leading-zero blanking applies when `lz_blank_en`=1. Digit i (i≥1) is blanked if buffered digits i..`NUM_DIGITS`-1 are all 0. Digit 0 is never blanked.
- Buffered codes 10–15 pass through unchanged to `dec_digit`; the decoder blanks them.
- State machine per slot:
  - **DEAD**, only with the macro, while `cnt` < `BLANK_CYCLES`:
    - `an_n` all 1, `dec_digit`=4'hF, `dp_n`=1.
  - **DRIVE**, otherwise:
    - if digit `idx` is blanked: `an_n` all 1, `dec_digit`=4'hF, `dp_n`=1;
    - else: `an_n` has only bit `idx` low, `dec_digit`=buffered digit `idx`, `dp_n`=~buffered `dp_in[idx]`.
  - Transitions: DEAD→DRIVE when `cnt` reaches `BLANK_CYCLES`. DRIVE→DEAD on slot wrap.
- `frame_tick`=1 in the output cycle corresponding to `idx`=0, `cnt`=0, except for the first such slot after reset.
- `lz_blank_en` is sampled live, not buffered. It takes effect at the next output cycle.

## Timing
- All outputs are registered, with one cycle of latency from `cnt`/`idx` to the pins.
- Reset values: `cnt`=0, `idx`=0, `an_n`=all 1, `dec_digit`=4'hF, `dp_n`=1, `frame_tick`=0.
- First cycle after `rst` deasserts: `cnt`=0, `idx`=0. Outputs for that state appear on the following cycle.
- Frame period is exactly `NUM_DIGITS`*`REFRESH_DIV` cycles, and `frame_tick` is exactly that periodic.
- Reset mid-slot: at the next edge, outputs return to reset values and scanning restarts at digit 0.
- A buffer capture and a new `digits_in` arriving on the same cycle: the value present on that cycle is captured.

## Configuration
- `SEG_SCAN_DEADTIME_EN` defined: each slot begins with `BLANK_CYCLES` DEAD cycles, giving anti-ghosting dead time. Lit time per slot is `REFRESH_DIV`-`BLANK_CYCLES`.
- Not defined: no DEAD state. DRIVE holds for the whole slot, and `BLANK_CYCLES` is ignored.

## Test plan
Bench parameters: `NUM_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.

- **Reset:** hold `rst` for 3 cycles → `an_n`=4'b1111, `dec_digit`=F, `dp_n`=1, `frame_tick`=0. The first DRIVE cycle after deassert shows `an_n`=4'b1110.
- **Scan order:** `digits_in`=16'h1234, no macro → 8 cycles each of (`an_n`=1110, code 4), (1101, 3), (1011, 2), (0111, 1). `frame_tick` pulses every 32 cycles.
- **Dead time:** same stimulus with the macro → each slot shows 2 cycles of `an_n`=1111 with code F, then 6 cycles driven.
- **Leading-zero blanking:** `digits_in`=16'h0005, `lz_blank_en`=1 → digits 3..1 are dark with code F and `dp_n`=1; digit 0 shows 5. `digits_in`=16'h0000 → only digit 0 is lit, showing 0.
- **Tear-free update:** change `digits_in` from 16'h1234 to 16'h5678 during digit 2's slot → the rest of that frame still shows 2, 1. The next frame shows 8, 7, 6, 5.
- **Decimal point and mid-frame reset:** `dp_in`=4'b0100 → `dp_n`=0 only during digit 2 DRIVE. Assert `rst` mid-slot → reset outputs on the next cycle, then scanning resumes at digit 0.
